// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: strobes rows, debounces over whole scans, hands out one code per press.
// Latency: key_valid rises one clock after the scan end that accepts the key.
// Backpressure: a key accepted while key_valid=1 and key_ready=0 is dropped and sets sticky overrun.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] row_drive,
  input  logic [2:0] col_in,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun,
  input  logic       ovr_clr
);

  localparam int             SW        = $clog2(SCAN_DIV);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [3:0]     DB_N      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  logic [2:0]    col_meta_q;
  logic [2:0]    col_sync_q;
  logic          active_q;
  logic [SW-1:0] slot_q;
  logic [1:0]    row_q;
  logic [3:0]    row_drive_q;
  logic [11:0]   snap_q;
  state_e        state_q;
  logic [3:0]    cand_q;
  logic [3:0]    cnt_q;
  logic [3:0]    rel_cnt_q;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          overrun_q;

  logic          slot_end;
  logic          scan_end;
  logic [11:0]   snap_full;
  logic          cls_none;
  logic          cls_single;
  logic [3:0]    cls_code;
  logic          emit;

  assign row_drive = row_drive_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

  // Slot end is gated by en so a dropped enable can never produce a scan end.
  assign slot_end = en && active_q && (slot_q == SLOT_LAST);
  assign scan_end = slot_end && (row_q == 2'd3);

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= '0;
      col_sync_q <= '0;
    end else begin
      col_meta_q <= col_in;
      col_sync_q <= col_meta_q;
    end
  end

  // Row strobe, slot divider and per-row column snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      slot_q      <= '0;
      row_q       <= '0;
      row_drive_q <= '0;
      snap_q      <= '0;
    end else if (!en) begin
      active_q    <= 1'b0;
      slot_q      <= '0;
      row_q       <= '0;
      row_drive_q <= '0;
      snap_q      <= '0;
    end else if (!active_q) begin
      // First enabled edge puts row 0 on the bus; slot counting starts from here.
      active_q    <= 1'b1;
      slot_q      <= '0;
      row_q       <= '0;
      row_drive_q <= 4'b0001;
    end else if (slot_end) begin
      slot_q      <= '0;
      row_q       <= row_q + 2'd1;
      row_drive_q <= {row_drive_q[2:0], row_drive_q[3]};
      snap_q      <= snap_full;
    end else begin
      slot_q      <= slot_q + SW'(1);
    end
  end

  // Snapshot including the row being sampled now, then classify it.
  always_comb begin
    snap_full = snap_q;
    snap_full[int'(row_q) * 3 +: 3] = col_sync_q;
    cls_none   = (snap_full == 12'd0);
    cls_single = ($countones(snap_full) == 1);
    cls_code   = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (snap_full[i]) cls_code = 4'(i);
    end
  end

  // A key is accepted on the scan that completes the debounce run.
  always_comb begin
    emit = 1'b0;
    if (scan_end && cls_single) begin
      if (state_q == ST_SCAN && DB_N == 4'd1) begin
        emit = 1'b1;
      end else if (state_q == ST_DEBOUNCE && cls_code == cand_q && (cnt_q + 4'd1) == DB_N) begin
        emit = 1'b1;
      end
    end
  end

  // Debounce FSM: advances only at scan end, parks in SCAN while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SCAN;
      cand_q    <= '0;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
    end else if (!en) begin
      state_q   <= ST_SCAN;
      cand_q    <= '0;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
    end else if (scan_end) begin
      case (state_q)
        ST_SCAN: begin
          if (cls_single) begin
            cand_q <= cls_code;
            if (DB_N == 4'd1) begin
              state_q <= ST_HELD;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_DEBOUNCE;
              cnt_q   <= 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (cls_single && cls_code == cand_q) begin
            if ((cnt_q + 4'd1) == DB_N) begin
              state_q   <= ST_HELD;
              cnt_q     <= '0;
              rel_cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            state_q <= ST_SCAN;
            cnt_q   <= '0;
          end
        end
        ST_HELD: begin
          if (cls_none) begin
            if ((rel_cnt_q + 4'd1) == DB_N) begin
              rel_cnt_q <= '0;
              state_q   <= ST_SCAN;
            end else begin
              rel_cnt_q <= rel_cnt_q + 4'd1;
            end
          end else begin
            rel_cnt_q <= '0;
          end
        end
        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  // Output handshake and sticky overrun; independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ovr_clr) overrun_q <= 1'b0;
      if (emit) begin
        if (!key_valid_q || key_ready) begin
          key_code_q  <= cls_code;
          key_valid_q <= 1'b1;
        end else begin
          // Drop wins over a same-cycle clear.
          overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=2 (one scan = 16 clocks).
// A behavioural keypad drives col_in from the pressed-key mask and row_drive.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] row_drive;
  logic [2:0] col_in;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overrun;
  logic       ovr_clr;

  logic [11:0] pressed;
  int          n_tests;
  int          n_fail;
  int          pulses;
  int          base;
  logic [3:0]  last_code;
  logic        kv_prev;

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .row_drive (row_drive),
    .col_in    (col_in),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its row strobe to its column.
  always_comb begin
    col_in = 3'b000;
    for (int k = 0; k < 12; k++) begin
      if (pressed[k] && row_drive[k / 3]) col_in[k % 3] = 1'b1;
    end
  end

  // Count rising edges of key_valid (one per delivered key).
  initial begin
    pulses    = 0;
    kv_prev   = 1'b0;
    last_code = 4'd0;
  end
  always @(negedge clk) begin
    if (key_valid && !kv_prev) begin
      pulses    = pulses + 1;
      last_code = key_code;
    end
    kv_prev = key_valid;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset with the given key mask held; releases on a falling edge so the next rising edge is E0.
  task automatic do_reset(input logic [11:0] mask, input logic rdy);
    rst_n     = 1'b0;
    en        = 1'b1;
    key_ready = rdy;
    ovr_clr   = 1'b0;
    pressed   = mask;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    en        = 1'b1;
    key_ready = 1'b1;
    ovr_clr   = 1'b0;
    pressed   = '0;

    // Reset state
    tick(3);
    check("rst_row", int'(row_drive), 0);
    check("rst_kv", int'(key_valid), 0);
    check("rst_code", int'(key_code), 0);
    check("rst_ovr", int'(overrun), 0);
    check("rst_state", int'(dut.state_q), 0);

    // Key 4 (row 1, col 1) held for many scans
    do_reset(12'h010, 1'b1);
    base = pulses;
    tick(1);
    check("row0_first_edge", int'(row_drive), 1);
    tick(4);
    check("row1_step", int'(row_drive), 2);
    tick(27);
    check("k4_before_accept", int'(key_valid), 0);
    tick(1);
    check("k4_valid", int'(key_valid), 1);
    check("k4_code", int'(key_code), 4);
    tick(1);
    check("k4_consumed", int'(key_valid), 0);
    check("k4_code_hold", int'(key_code), 4);
    tick(62);
    check("k4_no_repeat", pulses - base, 1);
    pressed = '0;
    tick(48);
    check("k4_release_state", int'(dut.state_q), 0);
    check("k4_total_pulses", pulses - base, 1);

    // Single-scan tap of key 4
    do_reset(12'h010, 1'b1);
    base = pulses;
    tick(16);
    pressed = '0;
    tick(64);
    check("tap_no_emit", pulses - base, 0);

    // Keys 0 and 8 together
    do_reset(12'h101, 1'b1);
    base = pulses;
    tick(24);
    check("multi_state_mid", int'(dut.state_q), 0);
    tick(24);
    check("multi_state_end", int'(dut.state_q), 0);
    check("multi_no_emit", pulses - base, 0);
    pressed = '0;

    // Backpressure: key 2 pending, key 5 dropped
    do_reset(12'h004, 1'b0);
    base = pulses;
    tick(48);
    pressed = '0;
    tick(48);
    pressed = 12'h020;
    tick(48);
    pressed = '0;
    tick(16);
    check("bp_valid", int'(key_valid), 1);
    check("bp_code", int'(key_code), 2);
    check("bp_overrun", int'(overrun), 1);
    check("bp_pulses", pulses - base, 1);
    ovr_clr   = 1'b1;
    key_ready = 1'b1;
    tick(1);
    ovr_clr = 1'b0;
    check("bp_ovr_cleared", int'(overrun), 0);
    check("bp_valid_cleared", int'(key_valid), 0);
    check("bp_code_kept", int'(key_code), 2);

    // en drop mid-debounce, then reset mid-held
    do_reset(12'h010, 1'b1);
    base = pulses;
    tick(20);
    check("en_pre_debounce", int'(dut.state_q), 1);
    en = 1'b0;
    tick(1);
    check("en_off_row", int'(row_drive), 0);
    check("en_off_state", int'(dut.state_q), 0);
    tick(40);
    check("en_off_no_emit", pulses - base, 0);
    en = 1'b1;
    tick(1);
    check("en_restart_row", int'(row_drive), 1);
    tick(32);
    check("en_restart_valid", int'(key_valid), 1);
    check("en_restart_code", int'(key_code), 4);
    tick(8);
    check("held_state", int'(dut.state_q), 2);
    pressed = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_row", int'(row_drive), 0);
    check("arst_state", int'(dut.state_q), 0);
    check("arst_valid", int'(key_valid), 0);
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("arst_restart_row", int'(row_drive), 1);
    tick(48);
    check("arst_pulses", pulses - base, 1);

    // Key 7 bounce: on, off, on, on
    do_reset(12'h080, 1'b1);
    base = pulses;
    tick(16);
    pressed = '0;
    tick(16);
    pressed = 12'h080;
    tick(32);
    check("bounce_before", int'(key_valid), 0);
    check("bounce_none_yet", pulses - base, 0);
    tick(1);
    check("bounce_valid", int'(key_valid), 1);
    check("bounce_code", int'(key_code), 7);
    pressed = '0;
    tick(64);
    check("bounce_pulses", pulses - base, 1);
    check("bounce_last_code", int'(last_code), 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
